led_cmd_framer: RTL and testbench

Assembles 12-bit LED-manager commands from a byte stream, typically UART receiver output, and issues them on the `cmd_buf`/`new_cmd` interface consumed by `led_mgr`. It frames each command as a head/tail byte pair, drops malformed or stalled frames, and counts errors. It sits between the serial byte receiver and `led_mgr`, and is the producing end of the command interface.

---
 rtl/led_cmd_framer_pkg.sv | 30 +++
 rtl/frame_timer.sv | 31 +++
 rtl/led_cmd_framer.sv | 107 ++++++++++
 tb/tb_led_cmd_framer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_cmd_framer_pkg.sv
// Shared command-interface definitions for led_cmd_framer and led_mgr:
// command field layout, frame marker bits, opcodes and framer FSM states.
package led_cmd_framer_pkg;

  localparam int CMD_W    = 12;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 7;
  localparam int OP_MSB   = 6;
  localparam int OP_LSB   = 4;
  localparam int ARG_MSB  = 3;
  localparam int ARG_LSB  = 0;

  // Bit 7 distinguishes head (1) from tail (0); bit 6 must always be 0.
  localparam int HEAD_BIT = 7;
  localparam int RSVD_BIT = 6;

  localparam logic [2:0] CMD_SET = 3'd0;
  localparam logic [2:0] CMD_RST = 3'd1;
  localparam logic [2:0] CMD_ON  = 3'd2;
  localparam logic [2:0] CMD_OFF = 3'd3;
  localparam logic [2:0] CMD_TGL = 3'd4;
  localparam logic [2:0] CMD_SHL = 3'd5;
  localparam logic [2:0] CMD_SHR = 3'd6;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_TAIL = 1'b1
  } state_t;

endpackage

// File: rtl/frame_timer.sv
// Clearable, enabled idle-cycle counter; expired is high once TIMEOUT_CYCLES
// enabled cycles have been counted since the last clear.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Expiry is combinational so a byte in the same cycle can override it.
  assign expired = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_cmd_framer.sv
// Frames head/tail byte pairs from a byte stream into 12-bit led_mgr commands,
// dropping malformed or stalled frames and counting errors (saturating).
module led_cmd_framer
  import led_cmd_framer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [CMD_W-1:0] cmd_buf,
  output logic             new_cmd,
  output logic             frame_err,
  output logic [7:0]       err_count,
  output state_t           fsm_state
);

  state_t           state, state_next;
  logic [5:0]       staged, staged_next;
  logic [CMD_W-1:0] cmd_next;
  logic             new_cmd_next;
  logic             err_next;
  logic             timer_clr, timer_en, timer_expired;
  logic             is_rsvd, is_head;

  assign is_rsvd   = rx_data[RSVD_BIT];
  assign is_head   = rx_data[HEAD_BIT];
  assign fsm_state = state;

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_next   = state;
    staged_next  = staged;
    cmd_next     = cmd_buf;
    new_cmd_next = 1'b0;
    err_next     = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    case (state)
      IDLE: begin
        timer_clr = 1'b1;
        if (rx_valid) begin
          if (!is_rsvd && is_head) begin
            staged_next = rx_data[5:0];
            state_next  = WAIT_TAIL;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      WAIT_TAIL: begin
        // A byte always takes precedence over a coincident timer expiry.
        if (rx_valid) begin
          timer_clr = 1'b1;
          if (is_rsvd) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else if (is_head) begin
            err_next    = 1'b1;
            staged_next = rx_data[5:0];
          end else begin
            cmd_next     = {staged, rx_data[5:0]};
            new_cmd_next = 1'b1;
            state_next   = IDLE;
          end
        end else if (timer_expired) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      staged    <= '0;
      cmd_buf   <= '0;
      new_cmd   <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_next;
      staged    <= staged_next;
      cmd_buf   <= cmd_next;
      new_cmd   <= new_cmd_next;
      frame_err <= err_next;
      if (err_next && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_cmd_framer.sv
// Directed bench for led_cmd_framer: expected outputs are queued as bytes are
// driven and a negedge monitor pops one entry per new_cmd / frame_err pulse.
module tb_led_cmd_framer;
  import led_cmd_framer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] cmd_buf;
  logic        new_cmd;
  logic        frame_err;
  logic [7:0]  err_count;
  state_t      fsm_state;

  // Entry: {new_cmd, frame_err, err_count[7:0], cmd_buf[11:0]}
  logic [21:0] exp_q[$];
  logic [11:0] exp_cmd;
  logic [7:0]  exp_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  led_cmd_framer #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_buf  (cmd_buf),
    .new_cmd  (new_cmd),
    .frame_err(frame_err),
    .err_count(err_count),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic expect_cmd(input logic [11:0] c);
    exp_cmd = c;
    exp_q.push_back({1'b1, 1'b0, exp_cnt, exp_cmd});
  endtask

  task automatic expect_err();
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({1'b0, 1'b1, exp_cnt, exp_cmd});
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    idle(4);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every output pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && (new_cmd || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none at %0t",
                 {new_cmd, frame_err, err_count, cmd_buf}, $time);
      end else begin
        check("output_pulse", {new_cmd, frame_err, err_count, cmd_buf}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    exp_cmd  = 12'h000;
    exp_cnt  = 8'h00;
    #1;
    check("reset_cmd_buf", cmd_buf, 0);
    check("reset_new_cmd", new_cmd, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_err_count", err_count, 0);
    check("reset_state", fsm_state, IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame, head then tail back-to-back.
    expect_cmd(12'hA53);
    send(8'hA9);
    send(8'h13);
    drain("basic_frame");

    // Back-to-back frames with no bubble.
    send(8'h9F);
    expect_cmd(12'h7FF);
    send(8'h3F);
    send(8'h80);
    expect_cmd(12'h02A);
    send(8'h2A);
    drain("back_to_back");

    // Stray tail in IDLE: error only, cmd_buf unchanged.
    expect_err();
    send(8'h13);
    drain("stray_tail");
    check("stray_tail_cmd_hold", cmd_buf, 12'h02A);

    // New head while waiting replaces the old one.
    send(8'hA9);
    expect_err();
    send(8'h80);
    expect_cmd(12'h001);
    send(8'h01);
    drain("head_restart");

    // Timeout after 8 idle cycles, then the tail is stray.
    send(8'hA9);
    expect_err();
    idle(8);
    expect_err();
    send(8'h13);
    drain("timeout");
    check("timeout_cmd_hold", cmd_buf, 12'h001);

    // Tail in the expiry cycle wins over the timeout.
    send(8'hA9);
    idle(7);
    expect_cmd(12'hA53);
    send(8'h13);
    drain("expiry_boundary");

    // Reserved bit set while waiting aborts the frame.
    send(8'hA9);
    expect_err();
    send(8'h53);
    expect_err();
    send(8'h13);
    drain("rsvd_in_wait");

    // Reserved byte in IDLE, then saturate the error counter.
    expect_err();
    send(8'hC0);
    for (int i = 0; i < 300; i++) begin
      expect_err();
      send(8'h13);
    end
    drain("saturation");
    check("err_count_saturated", err_count, 8'hFF);

    // Reset mid-frame drops the staged head.
    send(8'hA9);
    #2;
    rst = 1'b1;
    #1;
    check("midframe_rst_cmd_buf", cmd_buf, 0);
    check("midframe_rst_err_count", err_count, 0);
    check("midframe_rst_state", fsm_state, IDLE);
    exp_cmd = 12'h000;
    exp_cnt = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_err();
    send(8'h13);
    drain("post_rst_tail");
    expect_cmd(12'hA53);
    send(8'hA9);
    send(8'h13);
    drain("post_rst_frame");
    check("final_err_count", err_count, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
